// File: rtl/picorv32_mem_sram.sv
// Word-organised SRAM slave for the PicoRV32 native memory bus.
// Each request has a fixed latency of WAIT_STATES+1 cycles and the result is registered.
module picorv32_mem_sram #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic        busy
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  count;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        oor_q;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] offset_now;
    logic        oor_now;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_oor;
    logic [31:0] sel_offset;
    logic [AW-1:0] idx;
    logic        enter_resp;

    // Subtracting the base makes addresses below BASE_ADDR wrap to huge values,
    // so a single unsigned compare covers both ends of the window.
    assign offset_now = mem_addr - BASE_ADDR;
    assign oor_now    = (offset_now >= MEM_BYTES);

    // With zero wait states the access happens on the accepting edge itself,
    // so the live bus is used instead of the not-yet-latched copy.
    always_comb begin
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        sel_wstrb = wstrb_q;
        sel_oor   = oor_q;
        if (state == IDLE) begin
            sel_addr  = mem_addr;
            sel_wdata = mem_wdata;
            sel_wstrb = mem_wstrb;
            sel_oor   = oor_now;
        end
    end

    assign sel_offset = sel_addr - BASE_ADDR;
    assign idx        = sel_offset[AW+1:2];

    always_comb begin
        enter_resp = 1'b0;
        if (resetn) begin
            if (state == IDLE && mem_valid && ZERO_WAIT)
                enter_resp = 1'b1;
            else if (state == WAIT && count == 3'd0)
                enter_resp = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            count     <= 3'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            oor_q     <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        oor_q   <= oor_now;
                        if (ZERO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (count == 3'd0)
                        state <= RESP;
                    else
                        count <= count - 3'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            mem_ready <= enter_resp;
            if (enter_resp) begin
                mem_rdata <= sel_oor ? 32'h0 : mem[idx];
                if (sel_oor)
                    err <= 1'b1;
            end
        end
    end

    // The array is deliberately left without reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (enter_resp && !sel_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_wstrb[i])
                    mem[idx][8*i +: 8] <= sel_wdata[8*i +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_instr, sel_offset[31:AW+2], sel_offset[1:0]};

endmodule

// File: tb/tb_picorv32_mem_sram.sv
// Directed bench for picorv32_mem_sram: three instances cover 1, 0 and 7 wait states.
module tb_picorv32_mem_sram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        valid [3];
    logic        instr [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        busy  [3];

    int checks = 0;
    int passed = 0;

    // Index 0: one wait state, index 1: zero wait states, index 2: seven wait states.
    picorv32_mem_sram #(.MEM_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_ws1 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_instr(instr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .err(err[0]), .busy(busy[0]));

    picorv32_mem_sram #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_ws0 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_instr(instr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .err(err[1]), .busy(busy[1]));

    picorv32_mem_sram #(.MEM_WORDS(1024), .WAIT_STATES(7), .BASE_ADDR(32'h0)) dut_ws7 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_instr(instr[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
        .mem_ready(ready[2]), .mem_rdata(rdata[2]), .err(err[2]), .busy(busy[2]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Present one request for a single accepting edge, then wait (bounded) for mem_ready.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, output logic [31:0] rd,
                                 output int lat, output logic again);
        @(negedge clk);
        valid[d] = 1'b1;
        instr[d] = 1'b0;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        @(posedge clk);
        #1 valid[d] = 1'b0;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready[d]) begin
                lat = i;
                rd  = rdata[d];
                break;
            end
        end
        @(negedge clk);
        again = ready[d];
    endtask

    task automatic runAccess(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, input int exp_lat, input string tag,
                             output logic [31:0] rd);
        int   lat;
        logic again;
        applyStimulus(d, a, wd, ws, rd, lat, again);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_single_pulse"}, {31'b0, again}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          highs;
        int          consec;
        logic        prev;
        logic        saw_ready;

        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            instr[i] = 1'b0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            wstrb[i] = 4'h0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'b0, ready[0]}, 32'h0);
        checkOutput("rst_rdata", rdata[0], 32'h0);
        checkOutput("rst_err",   {31'b0, err[0]}, 32'h0);
        checkOutput("rst_busy",  {31'b0, busy[0]}, 32'h0);
        resetn = 1'b1;

        // Write then read, one wait state
        runAccess(0, 32'h10, 32'hA5A5_1234, 4'hF, 2, "wr10", rd);
        runAccess(0, 32'h10, 32'h0, 4'h0, 2, "rd10", rd);
        checkOutput("rd10_data", rd, 32'hA5A5_1234);

        // Byte strobes; the partial write returns the pre-write word
        runAccess(0, 32'h20, 32'hFFFF_FFFF, 4'hF, 2, "wr20_full", rd);
        runAccess(0, 32'h20, 32'h0000_0000, 4'b0101, 2, "wr20_part", rd);
        checkOutput("wr20_part_prewrite", rd, 32'hFFFF_FFFF);
        runAccess(0, 32'h20, 32'h0, 4'h0, 2, "rd20", rd);
        checkOutput("rd20_data", rd, 32'hFF00_FF00);

        // Out of range access and sticky err
        checkOutput("err_before_oor", {31'b0, err[0]}, 32'h0);
        runAccess(0, 32'h0, 32'h1122_3344, 4'hF, 2, "wr0", rd);
        runAccess(0, 32'h1000, 32'h0, 4'h0, 2, "rd_oor", rd);
        checkOutput("rd_oor_data", rd, 32'h0);
        checkOutput("rd_oor_err", {31'b0, err[0]}, 32'h1);
        runAccess(0, 32'h1000, 32'hDEAD_BEEF, 4'hF, 2, "wr_oor", rd);
        checkOutput("wr_oor_data", rd, 32'h0);
        runAccess(0, 32'h0, 32'h0, 4'h0, 2, "rd0", rd);
        checkOutput("rd0_unchanged", rd, 32'h1122_3344);
        checkOutput("err_sticky", {31'b0, err[0]}, 32'h1);

        // Request is latched: address/strobe changes during WAIT are ignored
        runAccess(0, 32'h14, 32'h5555_5555, 4'hF, 2, "wr14", rd);
        @(negedge clk);
        valid[0] = 1'b1;
        addr[0]  = 32'h10;
        wdata[0] = 32'h0;
        wstrb[0] = 4'h0;
        @(posedge clk);
        #1;
        addr[0]  = 32'h14;
        wstrb[0] = 4'hF;
        @(negedge clk);
        checkOutput("latch_busy_wait", {31'b0, busy[0]}, 32'h1);
        checkOutput("latch_ready_early", {31'b0, ready[0]}, 32'h0);
        @(negedge clk);
        checkOutput("latch_ready", {31'b0, ready[0]}, 32'h1);
        checkOutput("latch_data", rdata[0], 32'hA5A5_1234);
        valid[0] = 1'b0;
        wstrb[0] = 4'h0;
        @(negedge clk);
        checkOutput("latch_idle_busy", {31'b0, busy[0]}, 32'h0);
        checkOutput("latch_ready_off", {31'b0, ready[0]}, 32'h0);
        runAccess(0, 32'h14, 32'h0, 4'h0, 2, "rd14", rd);
        checkOutput("rd14_unchanged", rd, 32'h5555_5555);

        // Zero wait states, mem_valid held continuously
        runAccess(1, 32'h8, 32'h0BAD_F00D, 4'hF, 1, "z_wr8", rd);
        runAccess(1, 32'h8, 32'h0, 4'h0, 1, "z_rd8", rd);
        checkOutput("z_rd8_data", rd, 32'h0BAD_F00D);
        @(negedge clk);
        valid[1] = 1'b1;
        addr[1]  = 32'h8;
        wstrb[1] = 4'h0;
        highs  = 0;
        consec = 0;
        prev   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready[1]) begin
                highs++;
                if (prev)
                    consec++;
            end
            prev = ready[1];
        end
        valid[1] = 1'b0;
        checkOutput("z_stream_pulses", 32'(highs), 32'd5);
        checkOutput("z_stream_back_to_back", 32'(consec), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a seven-wait-state write
        runAccess(2, 32'h40, 32'hCAFE_F00D, 4'hF, 8, "s_wr40", rd);
        runAccess(2, 32'h1000, 32'h0, 4'h0, 8, "s_rd_oor", rd);
        checkOutput("s_err_set", {31'b0, err[2]}, 32'h1);
        @(negedge clk);
        valid[2] = 1'b1;
        addr[2]  = 32'h40;
        wdata[2] = 32'h0000_0001;
        wstrb[2] = 4'hF;
        @(posedge clk);
        #1 valid[2] = 1'b0;
        wstrb[2] = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("s_busy_mid", {31'b0, busy[2]}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("s_rst_ready", {31'b0, ready[2]}, 32'h0);
        checkOutput("s_rst_busy",  {31'b0, busy[2]}, 32'h0);
        checkOutput("s_rst_err",   {31'b0, err[2]}, 32'h0);
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready[2])
                saw_ready = 1'b1;
        end
        checkOutput("s_no_ready_after_abort", {31'b0, saw_ready}, 32'h0);
        runAccess(2, 32'h40, 32'h0, 4'h0, 8, "s_rd40", rd);
        checkOutput("s_rd40_prior", rd, 32'hCAFE_F00D);
        checkOutput("s_err_after", {31'b0, err[2]}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_sram.md
PICORV32_MEM_SRAM -- requirements
Module: picorv32_mem_sram

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024: memory depth in 32-bit words, a power of two, 16..65536.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1: extra latency cycles per access, 0..7.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address, aligned to 4*MEM_WORDS.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port mem_valid, input, 1: CPU request pending.
REQ-007 The block SHALL have port mem_instr, input, 1: request is an instruction fetch; it is informational only.
REQ-008 The block SHALL have port mem_addr, input, 32: byte address; bits [1:0] are ignored.
REQ-009 The block SHALL have port mem_wdata, input, 32: write data.
REQ-010 The block SHALL have port mem_wstrb, input, 4: byte write enables; 4'b0000 means read.
REQ-011 The block SHALL have port mem_ready, output, 1: one-cycle response strobe.
REQ-012 The block SHALL have port mem_rdata, output, 32: read data, valid while mem_ready=1.
REQ-013 The block SHALL have port err, output, 1: sticky out-of-range access flag.
REQ-014 The block SHALL have port busy, output, 1: high while in WAIT or RESP.

Function
REQ-015 The block SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with mem_valid=1 at a clock edge, the block SHALL latch mem_addr, mem_wdata, mem_wstrb and the range check, then enter WAIT, or enter RESP directly if WAIT_STATES=0.
REQ-017 In WAIT, a 3-bit counter loaded with WAIT_STATES-1 SHALL decrement each cycle, and the block SHALL enter RESP on the edge where the counter is 0.
REQ-018 Latency SHALL be exactly WAIT_STATES+1 cycles: mem_ready is high in the (WAIT_STATES+1)th cycle after the accepting edge, for exactly one cycle.
REQ-019 The memory access SHALL occur on the edge entering RESP; mem_rdata is registered and is updated only on that edge.
REQ-020 The word index SHALL be (latched_addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits.
REQ-021 On a write (wstrb != 0), only bytes with wstrb[i]=1 SHALL be updated, and mem_rdata SHALL return the pre-write word.
REQ-022 An address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) SHALL suppress the write, return mem_rdata=32'h0000_0000, still pulse mem_ready with the normal latency, and set err=1 on the RESP entry edge.
REQ-023 err SHALL clear only on reset.
REQ-024 From RESP, the block SHALL always return to IDLE; mem_valid sampled during RESP SHALL be ignored, so an access completes in at least 2 cycles.
REQ-025 Changes to mem_addr, mem_wdata or mem_wstrb after acceptance SHALL have no effect.
REQ-026 If mem_valid deasserts during WAIT (a protocol violation), the block SHALL still complete the latched access and pulse mem_ready.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While resetn=0, the block SHALL force: state=IDLE, counter=0, mem_ready=0, mem_rdata=32'h0, err=0, busy=0, all independent of clk.
REQ-029 Reset asserted mid-access SHALL abort the access: no write occurs unless the RESP-entry edge already happened, and no mem_ready pulse follows.
REQ-030 Memory array contents SHALL be neither reset nor initialised.
REQ-031 The first request SHALL be accepted on the first rising edge after resetn rises.

Verification
REQ-032 Scenario, write then read: WAIT_STATES=1, write 0xA5A5_1234 to 0x10 with wstrb=4'hF, then read 0x10 -> each mem_ready pulses in the 2nd cycle after acceptance; the read returns 0xA5A5_1234.
REQ-033 Scenario, byte strobes: write 0xFFFF_FFFF to 0x20, then write 0x0000_0000 with wstrb=4'b0101, then read -> returns 0xFF00_FF00.
REQ-034 Scenario, out of range: with MEM_WORDS=1024, read 0x0000_1000 -> mem_ready pulses, mem_rdata=0 and err=1; a following in-range read leaves err=1; word 0 is unchanged by a write to 0x1000.
REQ-035 Scenario, zero wait: with WAIT_STATES=0 and mem_valid held high continuously -> mem_ready is high every other cycle, never on two consecutive cycles.
REQ-036 Scenario, reset mid-access: with WAIT_STATES=7, assert resetn=0 during WAIT for a write of 0x1 to 0x40 -> mem_ready, busy and err drop immediately; a subsequent read of 0x40 shows the prior contents.
REQ-037 Scenario, latched request: change mem_addr from 0x10 to 0x14 during WAIT -> data for 0x10 is returned.
